ref_sample_buffer: RTL
======================

REF_SAMPLE_BUFFER -- requirements
Module: ref_sample_buffer

Interface
REQ-001 SHALL have parameter REF_LEN, default 33, number of reference samples per side; index 0 is the top-left corner sample.
REQ-002 SHALL have parameter PIX_W, default 8, sample bit width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge clocked.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load_start, input, 1 bit: pulse that begins a new block load.
REQ-006 SHALL have port load_valid, input, 1 bit: load beat strobe.
REQ-007 SHALL have port load_data, input, PIX_W bits: neighbour sample for the current beat.
REQ-008 SHALL have port load_avail, input, 1 bit: 1 = the sample is available, 0 = it needs substitution.
REQ-009 SHALL have port rd_addr, input, 8 bits: read index driven by the address arbiter.
REQ-010 SHALL have ports en_top and en_left, inputs, 1 bit each: select the top or left array for reading.
REQ-011 SHALL have port ref_pixel, output, PIX_W bits: read data.
REQ-012 SHALL have port ref_valid, output, 1 bit: ref_pixel is valid this cycle.
REQ-013 SHALL have port ready, output, 1 bit: the arrays are substituted and readable.
REQ-014 SHALL have port busy, output, 1 bit: a load or substitution is in progress.

Function
REQ-015 SHALL implement the FSM IDLE, LOAD_TOP, LOAD_LEFT, SCAN, FILL, READY.
REQ-016 IDLE or READY with load_start=1 SHALL go to LOAD_TOP, clear the beat counter and clear the found flag.
REQ-017 load_start in any other state SHALL be ignored.
REQ-018 In LOAD_TOP, each load_valid beat SHALL write top[cnt] and avail_top[cnt] and then increment cnt; after beat REF_LEN-1 the FSM SHALL go to LOAD_LEFT with cnt=0.
REQ-019 LOAD_LEFT SHALL behave the same on left[]/avail_left[]; the beat for left[0] SHALL be accepted and discarded; after the last beat the FSM SHALL go to SCAN.
REQ-020 Scan order SHALL be position k=0..2*REF_LEN-2, where k<REF_LEN-1 maps to left[REF_LEN-1-k] and other k map to top[k-REF_LEN+1].
REQ-021 SCAN SHALL visit one position per cycle; at the first available position it SHALL latch that sample as fill_val, set found, and go to FILL with k=0.
REQ-022 If SCAN exhausts all positions with nothing available, it SHALL set fill_val=1<<(PIX_W-1) (128 at PIX_W=8) and go to FILL.
REQ-023 FILL SHALL visit one position per cycle in scan order.
REQ-024 In FILL, an unavailable position SHALL be written with fill_val; an available position SHALL leave its sample intact and update fill_val to that sample.
REQ-025 After the last position, FILL SHALL write left[0]=top[0] and go to READY.
REQ-026 Reads SHALL be served only in READY, with 1-cycle latency.
REQ-027 en_top=1 in cycle N SHALL give ref_pixel=top[idx] and ref_valid=1 in cycle N+1.
REQ-028 en_left=1 (with en_top=0) SHALL read left[idx] the same way.
REQ-029 en_top and en_left both 1 SHALL read top (top has priority).
REQ-030 idx SHALL be rd_addr clamped to REF_LEN-1 when rd_addr>=REF_LEN.
REQ-031 With no enable, or when not in READY, ref_valid SHALL be 0 and ref_pixel SHALL hold its last value.
REQ-032 A load_start in READY SHALL drop ready the next cycle; a read issued in that same cycle SHALL still complete from the old contents.
REQ-033 ready SHALL be 1 only in READY; busy SHALL be 1 in LOAD_TOP, LOAD_LEFT, SCAN and FILL.
REQ-034 Array contents SHALL persist across READY→LOAD until overwritten.

Reset
REQ-035 On rst_n=0 (asynchronous), SHALL reset to state IDLE, cnt=0, k=0, found=0, fill_val=0, ref_pixel=0, ref_valid=0, ready=0, busy=0.
REQ-036 Array contents SHALL be undefined after reset; avail flags SHALL clear to 0.
REQ-037 Reset asserted mid-load or mid-FILL SHALL abort to IDLE with no partial READY.

Structure
REQ-038 Shared package SHALL hold the FSM state encoding, REF_LEN/PIX_W defaults, and the constant DC_FILL=128.
REQ-039 Scan-position-to-array index mapping SHALL be a single sub-module, ref_scan_map (k in, side select and index out), reused by SCAN and FILL.

Verification
REQ-040 All 66 beats available, data=index → ready after load + 1 SCAN cycle + 65 FILL cycles; top/left reads return loaded values, left[0]=top[0].
REQ-041 All load_avail=0 → every top and left read returns 128.
REQ-042 Only top[5]=200 available → left[*], top[0..4] read 200; top[6..32] read 200.
REQ-043 Available left[10]=50, top[3]=90, rest unavailable → left[32..11]=50, left[10..1]=50, top[0..2]=50, top[3..32]=90.
REQ-044 rd_addr=40 with en_left=1 → returns left[32]; en_top=en_left=1 returns top; read in IDLE → ref_valid=0.
REQ-045 rst_n pulsed during FILL → ready=0, busy=0; a new full load then completes correctly.

Source files
------------

// File: rtl/ref_sample_buffer_pkg.sv
// Shared definitions for the reference sample buffer: FSM state encoding,
// default geometry and the substitution value used when no neighbour exists.
package ref_sample_buffer_pkg;

    localparam int REF_LEN_DEF = 33;
    localparam int PIX_W_DEF   = 8;

    // Mid-grey for a given sample width.
    function automatic int dc_fill(input int w);
        return 1 << (w - 1);
    endfunction

    localparam int DC_FILL = dc_fill(PIX_W_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_TOP,
        ST_LOAD_LEFT,
        ST_SCAN,
        ST_FILL,
        ST_READY
    } state_e;

endpackage

// File: rtl/ref_scan_map.sv
// Maps a scan position k to an array side and index. Positions run from the
// bottom of the left column up to the corner, then along the top row.
module ref_scan_map #(
    parameter int REF_LEN = 33,
    parameter int KW      = $clog2(2 * REF_LEN - 1),
    parameter int IW      = $clog2(REF_LEN)
) (
    input  logic [KW-1:0] k_i,
    output logic          side_top_o,
    output logic [IW-1:0] idx_o
);

    localparam logic [KW-1:0] SPLIT = KW'(REF_LEN - 1);

    // Left column walked downwards-to-up (left[REF_LEN-1]..left[1]), then top[0..REF_LEN-1].
    always_comb begin
        if (k_i < SPLIT) begin
            side_top_o = 1'b0;
            idx_o      = IW'(SPLIT - k_i);
        end else begin
            side_top_o = 1'b1;
            idx_o      = IW'(k_i - SPLIT);
        end
    end

endmodule

// File: rtl/ref_sample_buffer.sv
// Reference sample buffer: loads top and left neighbour rows, substitutes
// unavailable samples by propagating the nearest available one along the scan
// order, then serves single-cycle-latency reads.
module ref_sample_buffer
    import ref_sample_buffer_pkg::*;
#(
    parameter int REF_LEN = REF_LEN_DEF,
    parameter int PIX_W   = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [PIX_W-1:0] load_data,
    input  logic             load_avail,
    input  logic [7:0]       rd_addr,
    input  logic             en_top,
    input  logic             en_left,
    output logic [PIX_W-1:0] ref_pixel,
    output logic             ref_valid,
    output logic             ready,
    output logic             busy
);

    localparam int IW = $clog2(REF_LEN);
    localparam int KW = $clog2(2 * REF_LEN - 1);
    localparam logic [IW-1:0]    LAST_CNT = IW'(REF_LEN - 1);
    localparam logic [KW-1:0]    LAST_K   = KW'(2 * REF_LEN - 2);
    localparam logic [7:0]       RD_LAST  = 8'(REF_LEN - 1);
    localparam logic [PIX_W-1:0] DC_VAL   = PIX_W'(dc_fill(PIX_W));

    state_e             state_q;
    logic [IW-1:0]      cnt_q;
    logic [KW-1:0]      k_q;
    logic               found_q;
    logic [PIX_W-1:0]   fill_val_q;
    logic [REF_LEN-1:0] avail_top_q;
    logic [REF_LEN-1:0] avail_left_q;
    logic               ready_q;
    logic               busy_q;
    logic [PIX_W-1:0]   ref_pixel_q;
    logic               ref_valid_q;

    // Sample storage carries no reset; contents persist across reloads.
    logic [PIX_W-1:0]   top_q  [REF_LEN];
    logic [PIX_W-1:0]   left_q [REF_LEN];

    logic               map_top;
    logic [IW-1:0]      map_idx;
    logic               cur_avail;
    logic [PIX_W-1:0]   cur_sample;
    logic               top_we;
    logic               left_we;
    logic               corner_we;
    logic [IW-1:0]      wr_idx;
    logic [PIX_W-1:0]   wr_data;
    logic [IW-1:0]      rd_idx;

    // One mapper shared by SCAN and FILL, both driven from k_q.
    ref_scan_map #(
        .REF_LEN (REF_LEN),
        .KW      (KW),
        .IW      (IW)
    ) u_scan_map (
        .k_i        (k_q),
        .side_top_o (map_top),
        .idx_o      (map_idx)
    );

    assign cur_avail  = map_top ? avail_top_q[map_idx] : avail_left_q[map_idx];
    assign cur_sample = map_top ? top_q[map_idx] : left_q[map_idx];
    assign rd_idx     = (rd_addr > RD_LAST) ? LAST_CNT : rd_addr[IW-1:0];

    assign ref_pixel = ref_pixel_q;
    assign ref_valid = ref_valid_q;
    assign ready     = ready_q;
    assign busy      = busy_q;

    // Array write strobes: load beats, substitution writes, and the corner copy.
    always_comb begin
        top_we    = 1'b0;
        left_we   = 1'b0;
        corner_we = 1'b0;
        wr_idx    = cnt_q;
        wr_data   = load_data;
        case (state_q)
            ST_LOAD_TOP:  top_we  = load_valid;
            // Beat for left[0] is swallowed; the corner lives in top[0].
            ST_LOAD_LEFT: left_we = load_valid && (cnt_q != '0);
            ST_FILL: begin
                wr_idx    = map_idx;
                wr_data   = fill_val_q;
                top_we    = !cur_avail && map_top;
                left_we   = !cur_avail && !map_top;
                corner_we = (k_q == LAST_K);
            end
            default: ;
        endcase
    end

    // Sample arrays; the corner copy targets left[0], which FILL never visits.
    always_ff @(posedge clk) begin
        if (top_we)    top_q[wr_idx]  <= wr_data;
        if (left_we)   left_q[wr_idx] <= wr_data;
        if (corner_we) left_q[0]      <= top_q[0];
    end

    // Control FSM with registered ready/busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            k_q          <= '0;
            found_q      <= 1'b0;
            fill_val_q   <= '0;
            avail_top_q  <= '0;
            avail_left_q <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_READY: begin
                    if (load_start) begin
                        state_q <= ST_LOAD_TOP;
                        cnt_q   <= '0;
                        found_q <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD_TOP: begin
                    if (load_valid) begin
                        avail_top_q[cnt_q] <= load_avail;
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            state_q <= ST_LOAD_LEFT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_LOAD_LEFT: begin
                    if (load_valid) begin
                        if (cnt_q != '0) avail_left_q[cnt_q] <= load_avail;
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            k_q     <= '0;
                            state_q <= ST_SCAN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (cur_avail && !found_q) begin
                        fill_val_q <= cur_sample;
                        found_q    <= 1'b1;
                        k_q        <= '0;
                        state_q    <= ST_FILL;
                    end else if (k_q == LAST_K) begin
                        fill_val_q <= DC_VAL;
                        k_q        <= '0;
                        state_q    <= ST_FILL;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                ST_FILL: begin
                    // Available samples become the new propagation value.
                    if (cur_avail) fill_val_q <= cur_sample;
                    if (k_q == LAST_K) begin
                        k_q     <= '0;
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read port: served only in READY, top wins when both enables are set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_pixel_q <= '0;
            ref_valid_q <= 1'b0;
        end else if ((state_q == ST_READY) && (en_top || en_left)) begin
            ref_pixel_q <= en_top ? top_q[rd_idx] : left_q[rd_idx];
            ref_valid_q <= 1'b1;
        end else begin
            ref_valid_q <= 1'b0;
        end
    end

endmodule
